// File: rtl/hu_hazard_ctrl.sv
// hu_hazard_ctrl: stall/flush strobes for load-use, EX redirects and memory waits.
// Define HU_MEM_WAIT_EN to enable multi-cycle data-memory waits and the watchdog.
module hu_hazard_ctrl #(
    parameter int unsigned WAIT_TIMEOUT = 16,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             MemRead_E,
    input  logic [4:0]       Rd_E,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic             rs1_used_D,
    input  logic             rs2_used_D,
    input  logic             redirect_E,
    input  logic             dmem_req_M,
`ifdef HU_MEM_WAIT_EN
    input  logic             dmem_ack_M,
`endif
    output logic             stall_F,
    output logic             stall_D,
    output logic             stall_E,
    output logic             stall_M,
    output logic             flush_D,
    output logic             flush_E,
    output logic             bubble_W,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic load_use;
    logic mem_busy;
    logic in_err;
    logic redir_take;

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;

    assign load_use = MemRead_E && (Rd_E != 5'd0) &&
                      ((rs1_used_D && (Rs1_D == Rd_E)) ||
                       (rs2_used_D && (Rs2_D == Rd_E)));

`ifdef HU_MEM_WAIT_EN
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_e;

    state_e      state_q;
    state_e      state_d;
    logic [15:0] wait_cnt_q;
    logic [15:0] wait_cnt_d;

    assign mem_busy = dmem_req_M && !dmem_ack_M;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // wait_cnt counts busy cycles spent so far, including the entry cycle
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            RUN: begin
                if (mem_busy) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 16'd1;
                end
            end
            MEM_WAIT: begin
                if (!mem_busy) begin
                    state_d = RUN;
                end else if (wait_cnt_q == 16'(WAIT_TIMEOUT)) begin
                    state_d = ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign in_err = (state_q == ERR);
`else
    logic unused_req;

    assign unused_req = dmem_req_M;
    assign mem_busy   = 1'b0;
    assign in_err     = 1'b0;
`endif

    always_comb begin
        stall_F    = 1'b0;
        stall_D    = 1'b0;
        stall_E    = 1'b0;
        stall_M    = 1'b0;
        flush_D    = 1'b0;
        flush_E    = 1'b0;
        bubble_W   = 1'b0;
        redir_take = 1'b0;
        if (rst_n) begin
            // a held E/D pair re-presents redirect/load-use after the wait
            if (in_err || mem_busy) begin
                stall_F  = 1'b1;
                stall_D  = 1'b1;
                stall_E  = 1'b1;
                stall_M  = 1'b1;
                bubble_W = 1'b1;
            end else if (redirect_E) begin
                flush_D    = 1'b1;
                flush_E    = 1'b1;
                redir_take = 1'b1;
            end else if (load_use) begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                flush_E = 1'b1;
            end
        end
    end

    assign mem_err = rst_n && in_err;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_F && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (redir_take && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hu_hazard_ctrl.sv
// Scoreboard bench for hu_hazard_ctrl: random + directed stimulus vs. a rule model.
module tb_hu_hazard_ctrl;

    localparam int WT   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
`ifdef HU_MEM_WAIT_EN
    localparam bit HAS_MW = 1'b1;
`else
    localparam bit HAS_MW = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n      = 1'b0;
    logic          MemRead_E  = 1'b0;
    logic [4:0]    Rd_E       = 5'd0;
    logic [4:0]    Rs1_D      = 5'd0;
    logic [4:0]    Rs2_D      = 5'd0;
    logic          rs1_used_D = 1'b0;
    logic          rs2_used_D = 1'b0;
    logic          redirect_E = 1'b0;
    logic          dmem_req_M = 1'b0;
    logic          dmem_ack_M = 1'b0;
    logic          stall_F, stall_D, stall_E, stall_M;
    logic          flush_D, flush_E, bubble_W, mem_err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    hu_hazard_ctrl #(.WAIT_TIMEOUT(WT), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .MemRead_E  (MemRead_E),
        .Rd_E       (Rd_E),
        .Rs1_D      (Rs1_D),
        .Rs2_D      (Rs2_D),
        .rs1_used_D (rs1_used_D),
        .rs2_used_D (rs2_used_D),
        .redirect_E (redirect_E),
        .dmem_req_M (dmem_req_M),
`ifdef HU_MEM_WAIT_EN
        .dmem_ack_M (dmem_ack_M),
`endif
        .stall_F    (stall_F),
        .stall_D    (stall_D),
        .stall_E    (stall_E),
        .stall_M    (stall_M),
        .flush_D    (flush_D),
        .flush_E    (flush_E),
        .bubble_W   (bubble_W),
        .mem_err    (mem_err),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    typedef struct packed {
        logic [7:0]    ctrl;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // model: consecutive busy cycles, sticky error, plain integer counters
    int m_run = 0;
    bit m_err = 1'b0;
    int m_sc  = 0;
    int m_fc  = 0;
    bit p_sf  = 1'b0;
    bit p_rt  = 1'b0;
    bit p_bsy = 1'b0;

    task automatic cyc(input bit rst, input bit mr, input logic [4:0] rd,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input bit u1, input bit u2, input bit rdr,
                       input bit req, input bit ack);
        exp_t e;
        bit   lu;
        bit   busy;
        @(posedge clk);
        #1;
        if (!m_err) begin
            if (p_bsy) begin
                m_run++;
                if (m_run > WT) m_err = 1'b1;
            end else begin
                m_run = 0;
            end
        end
        if (p_sf) m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
        if (p_rt) m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
        p_sf  = 1'b0;
        p_rt  = 1'b0;
        p_bsy = 1'b0;

        rst_n      = !rst;
        MemRead_E  = mr;
        Rd_E       = rd;
        Rs1_D      = r1;
        Rs2_D      = r2;
        rs1_used_D = u1;
        rs2_used_D = u2;
        redirect_E = rdr;
        dmem_req_M = req;
        dmem_ack_M = ack;

        e = '0;
        if (rst) begin
            m_err = 1'b0;
            m_run = 0;
            m_sc  = 0;
            m_fc  = 0;
        end else begin
            lu   = mr && (rd != 0) && ((u1 && r1 == rd) || (u2 && r2 == rd));
            busy = HAS_MW && req && !ack;
            p_bsy = busy;
            if (m_err) begin
                e.ctrl = 8'b1111_0011;
                p_sf   = 1'b1;
            end else if (busy) begin
                e.ctrl = 8'b1111_0010;
                p_sf   = 1'b1;
            end else if (rdr) begin
                e.ctrl = 8'b0000_1100;
                p_rt   = 1'b1;
            end else if (lu) begin
                e.ctrl = 8'b1100_0100;
                p_sf   = 1'b1;
            end
        end
        e.sc = CW'(m_sc);
        e.fc = CW'(m_fc);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t        e;
        logic [7:0]  act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {stall_F, stall_D, stall_E, stall_M,
                       flush_D, flush_E, bubble_W, mem_err};
                n_cmp++;
                if (act !== e.ctrl) begin
                    n_bad++;
                    $display("FAIL ctrl t=%0t got %b want %b", $time, act, e.ctrl);
                end
                n_cmp++;
                if (stall_cnt !== e.sc) begin
                    n_bad++;
                    $display("FAIL stall_cnt t=%0t got %0d want %0d",
                             $time, stall_cnt, e.sc);
                end
                n_cmp++;
                if (flush_cnt !== e.fc) begin
                    n_bad++;
                    $display("FAIL flush_cnt t=%0t got %0d want %0d",
                             $time, flush_cnt, e.fc);
                end
            end
        end
    end

    initial begin : stim
        int hang;
        bit r;
        bit rq;
        bit ak;
        hang = 0;
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        // load-use, load into x0, redirect over load-use
        cyc(0, 1, 5, 5, 0, 1, 0, 0, 0, 0);
        idle(1);
        cyc(0, 1, 0, 0, 0, 1, 1, 0, 0, 0);
        cyc(0, 1, 5, 5, 0, 1, 0, 1, 0, 0);
        cyc(0, 1, 7, 1, 7, 0, 1, 0, 0, 0);
        idle(1);
        // memory wait with ack in the fourth cycle, then same-cycle ack
        for (int i = 0; i < 3; i++) cyc(0, 1, 5, 5, 0, 1, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        idle(1);
        // watchdog, then reset in the middle of ERR
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        cyc(0, 1, 3, 3, 3, 1, 1, 1, 0, 0);
        cyc(1, 1, 3, 3, 3, 1, 1, 1, 1, 0);
        idle(2);
        // counter saturation
        for (int i = 0; i < 20; i++) cyc(0, 1, 9, 9, 9, 1, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            if (hang == 0 && $urandom_range(0, 39) == 0)
                hang = int'($urandom_range(3, 8));
            r  = ($urandom_range(0, 59) == 0);
            rq = (hang > 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
            ak = (hang > 0) ? 1'b0 : 1'($urandom_range(0, 1));
            if (hang > 0) hang--;
            cyc(r, 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 5) == 0), rq, ak);
        end
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hu_hazard_ctrl.md
# hu_hazard_ctrl

Pipeline hazard controller for the 5-stage RV32 core. Generates per-stage stall and flush strobes covering three cases: load-use hazards the EX-stage forwarding network cannot resolve, control redirects resolved in EX, and multi-cycle data-memory waits. It also runs a memory-wait watchdog and keeps saturating stall/flush statistics. It sits beside the forwarding unit and drives the enable/clear pins of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

## Interface
Parameters:
- WAIT_TIMEOUT, 16: cycles spent in MEM_WAIT before the watchdog fires; legal range 1..65535.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- MemRead_E  in  1  instruction in EX is a load.
- Rd_E  in  5  destination register of the EX instruction.
- Rs1_D, Rs2_D  in  5  source registers of the ID instruction.
- rs1_used_D, rs2_used_D  in  1  ID instruction actually reads Rs1/Rs2.
- redirect_E  in  1  taken branch or jump resolved in EX.
- dmem_req_M  in  1  MEM stage has an outstanding data-memory access.
- dmem_ack_M  in  1  data memory completes the access this cycle.
- stall_F, stall_D, stall_E, stall_M  out  1  hold the PC / IF-ID / ID-EX / EX-MEM register.
- flush_D, flush_E  out  1  clear IF-ID / ID-EX to a bubble.
- bubble_W  out  1  MEM-WB captures a bubble (RegWrite_W forced 0).
- mem_err  out  1  sticky watchdog error.
- stall_cnt  out  CNT_W  cycles with stall_F=1, saturating.
- flush_cnt  out  CNT_W  redirect events, saturating.

## Operation
- Condition definitions:
  - load_use = MemRead_E && Rd_E!=0 && ((rs1_used_D && Rs1_D==Rd_E) || (rs2_used_D && Rs2_D==Rd_E)).
  - mem_busy = dmem_req_M && !dmem_ack_M.
- FSM states: RUN, MEM_WAIT, ERR.
  - RUN -> MEM_WAIT when mem_busy; wait_cnt cleared to 1.
  - MEM_WAIT -> RUN when !mem_busy.
  - MEM_WAIT, still busy, wait_cnt==WAIT_TIMEOUT -> ERR; otherwise wait_cnt+1.
  - ERR is absorbing; only reset leaves it.
- Output priority, highest first:
  1. ERR: stall_F/D/E/M=1, bubble_W=1, flushes 0, mem_err=1.
  2. mem_busy (any state): stall_F/D/E/M=1, bubble_W=1, flushes 0. Redirect and load-use are ignored and re-evaluate once the stall releases, because the E and D registers are held.
  3. redirect_E: flush_D=1, flush_E=1, no stalls. A coincident load-use is dropped because the younger instruction is being discarded.
  4. load_use: stall_F=1, stall_D=1, flush_E=1 (one bubble into EX).
  5. Otherwise all 0.
- Combinational outputs are functions of the current state and the current inputs only.
- Counters:
  - stall_cnt +1 each cycle stall_F=1, including ERR.
  - flush_cnt +1 each cycle a redirect flush is issued (priority 3 taken).
  - Both counters hold at 2^CNT_W-1.

## Timing
- Load-use costs exactly 1 bubble. The next cycle, the load is in MEM and load_use is false, so the dependent instruction reaches EX and takes the value by forwarding.
- Redirect costs 2 flushed slots, asserted in the same cycle as redirect_E.
- Memory wait: stall asserted in the same cycle as mem_busy, released in the ack cycle. An ack in the request cycle gives zero stall cycles and no MEM_WAIT entry.
- Watchdog: with a continuous wait starting at cycle t, ERR is entered at the edge ending cycle t+WAIT_TIMEOUT. mem_err is visible from cycle t+WAIT_TIMEOUT+1.
- Reset (asynchronous, mid-operation included):
  - state=RUN, wait_cnt=0, mem_err=0, both counters 0.
  - While rst_n=0, every stall, flush and bubble output is forced to 0.

## Configuration
- HU_MEM_WAIT_EN defined: the dmem_ack_M port, MEM_WAIT/ERR states, watchdog, stall_M and bubble_W behave as above.
- HU_MEM_WAIT_EN undefined:
  - Memory is single-cycle: dmem_ack_M is not present and mem_busy is constant 0.
  - The FSM reduces to RUN.
  - stall_E, stall_M, bubble_W and mem_err are tied to 0.
  - Load-use and redirect behaviour is unchanged.

## Test plan
- Load-use: lw x5 in EX (MemRead_E=1, Rd_E=5), ID reads Rs1_D=5 -> one cycle of stall_F=stall_D=flush_E=1, then 0; stall_cnt=1.
- Load into x0: Rd_E=0, Rs1_D=0 -> no stall.
- Redirect: redirect_E=1 together with load_use=1 -> flush_D=flush_E=1, stall_F=0; flush_cnt increments by 1.
- Memory wait: dmem_req_M=1 with ack arriving after 3 cycles -> 3 cycles of all stalls plus bubble_W, state back to RUN, stall_cnt=3.
- Watchdog: WAIT_TIMEOUT=4, ack never arrives -> mem_err=1 from cycle 5 onward with stalls held; pulse rst_n low mid-ERR -> all outputs 0 and counters cleared.
- Saturation: CNT_W=4, 20 load-use events -> stall_cnt holds at 15.
